// File: rtl/mpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mpu_bus_master
// Purpose  : Pixel-write master for an MPU-style video controller bus, with a
//            shadow of the controller's auto-incrementing address register.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_bus_master #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [16:0] reqAddress,
    input  logic [7:0]  reqData,
    input  logic        invalidateShadow,
    output logic        busy,
    output logic        mpuChipSelect,
    output logic        mpuWriteEnable,
    output logic [2:0]  mpuRegisterSelect,
    inout  wire  [7:0]  mpuData
);

    localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES)
                           ? ((SETUP_CYCLES > RECOVERY_CYCLES) ? SETUP_CYCLES : RECOVERY_CYCLES)
                           : ((STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST    = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST   = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_CYCLES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR_LO  = 3'd1;
    localparam logic [2:0] ST_ADDR_MID = 3'd2;
    localparam logic [2:0] ST_ADDR_HI  = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;

    localparam logic [1:0] PH_SETUP    = 2'd0;
    localparam logic [1:0] PH_STROBE   = 2'd1;
    localparam logic [1:0] PH_RECOVER  = 2'd2;

    logic [2:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [16:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [2:0]       need_q, need_d;
    logic [16:0]      shadow_q, shadow_d;
    logic             shadowValid_q, shadowValid_d;
    logic             invPend_q, invPend_d;

    logic             shadowUsable;
    logic [2:0]       needNew;
    logic             driveBus;
    logic [7:0]       busByte;

    // Next register write after 'cur', skipping address bytes already in place.
    function automatic logic [2:0] f_next(input logic [2:0] cur, input logic [2:0] nd);
        logic [2:0] r;
        r = ST_DATA;
        if (cur == ST_IDLE && nd[0])
            r = ST_ADDR_LO;
        else if ((cur == ST_IDLE || cur == ST_ADDR_LO) && nd[1])
            r = ST_ADDR_MID;
        else if (cur != ST_ADDR_HI && nd[2])
            r = ST_ADDR_HI;
        return r;
    endfunction

    assign shadowUsable = shadowValid_q && !invalidateShadow;
    assign needNew[0]   = !shadowUsable || (reqAddress[7:0]  != shadow_q[7:0]);
    assign needNew[1]   = !shadowUsable || (reqAddress[15:8] != shadow_q[15:8]);
    assign needNew[2]   = !shadowUsable || (reqAddress[16]   != shadow_q[16]);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        need_d        = need_q;
        shadow_d      = shadow_q;
        shadowValid_d = shadowValid_q;
        invPend_d     = invPend_q;

        if (invalidateShadow) begin
            shadowValid_d = 1'b0;
            if (state_q != ST_IDLE)
                invPend_d = 1'b1;
        end

        if (state_q == ST_IDLE) begin
            if (reqValid) begin
                addr_d    = reqAddress;
                data_d    = reqData;
                need_d    = needNew;
                state_d   = f_next(ST_IDLE, needNew);
                phase_d   = PH_SETUP;
                cnt_d     = '0;
                invPend_d = 1'b0;
            end
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        phase_d = PH_STROBE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        phase_d = PH_RECOVER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt_q == RECOVERY_LAST) begin
                        phase_d = PH_SETUP;
                        cnt_d   = '0;
                        if (state_q == ST_DATA) begin
                            // Controller post-increments after the data write.
                            state_d       = ST_IDLE;
                            shadow_d      = addr_q + 17'd1;
                            shadowValid_d = !(invPend_q || invalidateShadow);
                        end else begin
                            state_d = f_next(state_q, need_q);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_SETUP;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            need_q        <= '0;
            shadow_q      <= '0;
            shadowValid_q <= 1'b0;
            invPend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            need_q        <= need_d;
            shadow_q      <= shadow_d;
            shadowValid_q <= shadowValid_d;
            invPend_q     <= invPend_d;
        end
    end

    assign reqReady       = (state_q == ST_IDLE);
    assign busy           = !reqReady;
    assign driveBus       = (state_q != ST_IDLE) && (phase_q != PH_RECOVER);
    assign mpuChipSelect  = !driveBus;
    assign mpuWriteEnable = !((state_q != ST_IDLE) && (phase_q == PH_STROBE));

    always_comb begin
        mpuRegisterSelect = 3'd0;
        busByte           = 8'h00;
        case (state_q)
            ST_ADDR_LO: begin
                mpuRegisterSelect = 3'd0;
                busByte           = addr_q[7:0];
            end
            ST_ADDR_MID: begin
                mpuRegisterSelect = 3'd1;
                busByte           = addr_q[15:8];
            end
            ST_ADDR_HI: begin
                mpuRegisterSelect = 3'd2;
                busByte           = {7'b0, addr_q[16]};
            end
            ST_DATA: begin
                mpuRegisterSelect = 3'd3;
                busByte           = data_q;
            end
            default: begin
                mpuRegisterSelect = 3'd0;
                busByte           = 8'h00;
            end
        endcase
    end

    assign mpuData = driveBus ? busByte : 8'bz;

endmodule
`default_nettype wire

// File: tb/tb_mpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpu_bus_master
// Purpose  : Randomized self-checking bench for mpu_bus_master against a
//            shadow-address reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpu_bus_master;

    localparam int S  = 1;
    localparam int T  = 2;
    localparam int R  = 1;
    localparam int WC = S + T + R;

    logic        clock = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic [16:0] reqAddress;
    logic [7:0]  reqData;
    logic        invalidateShadow;
    wire         reqReady;
    wire         busy;
    wire         mpuChipSelect;
    wire         mpuWriteEnable;
    wire  [2:0]  mpuRegisterSelect;
    wire  [7:0]  mpuData;

    mpu_bus_master #(
        .SETUP_CYCLES    (S),
        .STROBE_CYCLES   (T),
        .RECOVERY_CYCLES (R)
    ) dut (
        .clock             (clock),
        .resetN            (resetN),
        .reqValid          (reqValid),
        .reqReady          (reqReady),
        .reqAddress        (reqAddress),
        .reqData           (reqData),
        .invalidateShadow  (invalidateShadow),
        .busy              (busy),
        .mpuChipSelect     (mpuChipSelect),
        .mpuWriteEnable    (mpuWriteEnable),
        .mpuRegisterSelect (mpuRegisterSelect),
        .mpuData           (mpuData)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] rs;
        logic [7:0] d;
        int         su;
        int         st;
    } wr_t;

    int   vectors     = 0;
    int   miscompares = 0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    int   unstable    = 0;

    logic [16:0] m_sh;
    logic        m_valid;

    // Bus monitor: one record per completed write, plus protocol violations.
    logic       in_x = 1'b0;
    logic [2:0] cr;
    logic [7:0] cd;
    int         su, st;

    always @(negedge clock) begin
        if (!resetN) begin
            in_x = 1'b0;
            su   = 0;
            st   = 0;
        end else if (mpuChipSelect == 1'b0) begin
            if (!in_x) begin
                in_x = 1'b1;
                cr   = mpuRegisterSelect;
                cd   = mpuData;
                su   = 0;
                st   = 0;
            end else if (mpuRegisterSelect !== cr || mpuData !== cd) begin
                unstable++;
            end
            if (mpuWriteEnable) su++;
            else                st++;
        end else begin
            if (in_x) begin
                obs_q.push_back(wr_t'{cr, cd, su, st});
                in_x = 1'b0;
            end
            if (mpuWriteEnable !== 1'b1) unstable++;
        end
    end

    function automatic void build_expect(input logic [16:0] a, input logic [7:0] d, input logic inv);
        logic ok;
        ok = m_valid && !inv;
        exp_q.delete();
        if (!ok || a[7:0]  != m_sh[7:0])  exp_q.push_back(wr_t'{3'd0, a[7:0], S, T});
        if (!ok || a[15:8] != m_sh[15:8]) exp_q.push_back(wr_t'{3'd1, a[15:8], S, T});
        if (!ok || a[16]   != m_sh[16])   exp_q.push_back(wr_t'{3'd2, {7'b0, a[16]}, S, T});
        exp_q.push_back(wr_t'{3'd3, d, S, T});
    endfunction

    task automatic do_req(input logic [16:0] a, input logic [7:0] d, input logic inv,
                          input logic mid_inv, input string tag);
        int cyc;
        int ub;
        int n;
        build_expect(a, d, inv);
        @(negedge clock);
        obs_q.delete();
        ub = unstable;
        vectors++;
        if (reqReady !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready: got %b want 1", tag, reqReady);
        end
        reqValid         = 1'b1;
        reqAddress       = a;
        reqData          = d;
        invalidateShadow = inv;
        @(posedge clock);
        #1;
        reqValid         = 1'b0;
        invalidateShadow = 1'b0;
        reqAddress       = 17'($urandom);
        reqData          = 8'($urandom);
        cyc = 0;
        while (cyc < 1000) begin
            @(negedge clock);
            if (busy !== 1'b1) break;
            cyc++;
            invalidateShadow = (mid_inv && cyc == 2);
        end
        invalidateShadow = 1'b0;
        m_sh    = a + 17'd1;
        m_valid = !mid_inv;

        vectors++;
        if (cyc != exp_q.size() * WC) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d want %0d", tag, cyc, exp_q.size() * WC);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if ({obs_q[i].rs, obs_q[i].d} !== {exp_q[i].rs, exp_q[i].d}) begin
                miscompares++;
                $display("FAIL %s write%0d reg/data: got %0d/%h want %0d/%h", tag, i,
                         obs_q[i].rs, obs_q[i].d, exp_q[i].rs, exp_q[i].d);
            end
            vectors++;
            if (obs_q[i].su != exp_q[i].su || obs_q[i].st != exp_q[i].st) begin
                miscompares++;
                $display("FAIL %s write%0d setup/strobe: got %0d/%0d want %0d/%0d", tag, i,
                         obs_q[i].su, obs_q[i].st, exp_q[i].su, exp_q[i].st);
            end
        end
        vectors++;
        if (unstable != ub) begin
            miscompares++;
            $display("FAIL %s bus_stability: got %0d violations want 0", tag, unstable - ub);
        end
    endtask

    task automatic test_reset();
        resetN           = 1'b0;
        reqValid         = 1'b0;
        reqAddress       = '0;
        reqData          = '0;
        invalidateShadow = 1'b0;
        m_sh             = '0;
        m_valid          = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({reqReady, busy, mpuChipSelect, mpuWriteEnable, mpuRegisterSelect} !== 7'b1011_000) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b cs=%b we=%b rs=%0d want 1 0 1 1 0",
                     reqReady, busy, mpuChipSelect, mpuWriteEnable, mpuRegisterSelect);
        end
        resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        do_req(17'h12345, 8'hAB, 1'b0, 1'b0, "first_after_reset");
        do_req(17'h12346, 8'h07, 1'b0, 1'b0, "at_shadow");
    endtask

    task automatic test_carry();
        do_req(17'h123FF, 8'h11, 1'b0, 1'b0, "carry_setup");
        do_req(17'h12400, 8'h22, 1'b0, 1'b0, "carry_mid");
    endtask

    task automatic test_wrap();
        do_req(17'h1FFFF, 8'h33, 1'b0, 1'b0, "wrap_top");
        do_req(17'h00000, 8'h44, 1'b0, 1'b0, "wrap_zero");
        do_req(17'h00001, 8'h55, 1'b0, 1'b0, "wrap_after");
    endtask

    task automatic test_invalidate();
        do_req(m_sh, 8'h66, 1'b1, 1'b0, "inval_at_accept");
        do_req(m_sh, 8'h77, 1'b0, 1'b1, "inval_inflight");
        do_req(m_sh, 8'h88, 1'b0, 1'b0, "after_inflight_inval");
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        @(negedge clock);
        reqValid   = 1'b1;
        reqAddress = 17'h0ABCD;
        reqData    = 8'h99;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        cyc = 0;
        while (cyc < 50 && !(mpuChipSelect === 1'b0 && mpuWriteEnable === 1'b0)) begin
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (mpuWriteEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid reach_strobe: got we=%b want 0", mpuWriteEnable);
        end
        #2;
        resetN = 1'b0;
        #1;
        vectors++;
        if ({mpuChipSelect, mpuWriteEnable, reqReady, busy} !== 4'b1110) begin
            miscompares++;
            $display("FAIL rst_mid async_release: got cs=%b we=%b rdy=%b busy=%b want 1 1 1 0",
                     mpuChipSelect, mpuWriteEnable, reqReady, busy);
        end
        m_sh    = '0;
        m_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        do_req(17'h12345, 8'h5A, 1'b0, 1'b0, "after_mid_reset");
    endtask

    task automatic test_random();
        logic [16:0] a;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       a = m_sh;
                1:       a = m_sh ^ (17'd1 << $urandom_range(0, 16));
                2:       a = {m_sh[16:8] + 9'd1, 8'h00};
                default: a = 17'($urandom);
            endcase
            do_req(a, 8'($urandom), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 5) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_wrap();
        test_invalidate();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
